seq_fetch_unit: RTL and testbench

//  Parametrised instruction fetch front-end for the SEQUENCER. Reads wide words from the instruction SRAM
//  (1-cycle read latency, active-low CEB) and buffers up to DEPTH words in a FIFO.

---
 rtl/seq_fetch_unit.sv | 108 ++++++++++
 tb/tb_seq_fetch_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_fetch_unit.sv
// Instruction fetch front-end: streams wide SRAM words into a small FIFO and
// hands them out one INST_W slice at a time with its PC, with redirect and halt.
module seq_fetch_unit #(
  parameter int              MEM_W    = 256,
  parameter int              INST_W   = 32,
  parameter int              ADDR_W   = 14,
  parameter int              PC_W     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_purge,
  input  logic [PC_W-1:0]             i_purge_pc,
  input  logic                        i_halt,
  output logic [ADDR_W-1:0]           o_raddri,
  output logic                        o_rcebi,
  input  logic [MEM_W-1:0]            i_qi,
  output logic                        o_inst_valid,
  input  logic                        i_inst_ready,
  output logic [INST_W-1:0]           o_inst,
  output logic [PC_W-1:0]             o_inst_pc,
  output logic [$clog2(DEPTH):0]      o_level
);

  localparam int SLOTS  = MEM_W / INST_W;
  localparam int SLOT_W = $clog2(SLOTS);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr;
  logic              r_inflight;
  logic [MEM_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic [PC_W-1:0]   r_inst_pc;

  logic [LVL_W:0]    w_occupancy;
  logic              w_issue;
  logic              w_valid;
  logic              w_xfer;
  logic              w_pop;
  logic              w_push;
  logic [SLOT_W-1:0] w_slot;
  logic [MEM_W-1:0]  w_head;
  logic [INST_W-1:0] w_inst;

  // A read in flight already owns a FIFO entry, so issuing is credit-limited.
  assign w_occupancy = {1'b0, r_level} + {{LVL_W{1'b0}}, r_inflight};
  assign w_issue     = !i_rst && !i_purge && !i_halt &&
                       (w_occupancy < (LVL_W+1)'(DEPTH));

  assign w_valid = (r_level != '0) && !i_purge && !i_rst;
  assign w_xfer  = w_valid && i_inst_ready;

  // The slot tracks the low PC bits exactly, so it is taken from the PC itself.
  assign w_slot  = r_inst_pc[SLOT_W-1:0];
  assign w_pop   = w_xfer && (&w_slot);
  assign w_push  = r_inflight;
  assign w_head  = r_mem[r_rptr];
  assign w_inst  = w_head[w_slot*INST_W +: INST_W];

  assign o_rcebi      = !w_issue;
  assign o_raddri     = i_rst ? '0 : r_addr;
  assign o_inst_valid = w_valid;
  assign o_inst       = (i_rst || r_level == '0) ? '0 : w_inst;
  assign o_inst_pc    = i_rst ? RESET_PC : r_inst_pc;
  assign o_level      = i_rst ? '0 : r_level;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr     <= '0;
      r_inflight <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_inst_pc  <= RESET_PC;
    end else if (i_purge) begin
      r_addr     <= ADDR_W'(i_purge_pc >> SLOT_W);
      r_inflight <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_inst_pc  <= i_purge_pc;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_addr    <= r_addr + 1'b1;
      if (w_push)  r_wptr    <= r_wptr + 1'b1;
      if (w_pop)   r_rptr    <= r_rptr + 1'b1;
      if (w_xfer)  r_inst_pc <= r_inst_pc + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // NOTE: the word storage has no reset; entries are only read while r_level
  // says they hold data, so clearing the pointers is enough.
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_purge && w_push) r_mem[r_wptr] <= i_qi;
  end

endmodule

// File: tb/tb_seq_fetch_unit.sv
// Randomised and directed bench for seq_fetch_unit against a queue-based
// model of the fetch stream, with a behavioural 1-cycle-latency SRAM.
module tb_seq_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic         i_clk;
  logic         i_rst;
  logic         i_purge;
  logic [31:0]  i_purge_pc;
  logic         i_halt;
  logic [13:0]  o_raddri;
  logic         o_rcebi;
  logic [255:0] i_qi;
  logic         o_inst_valid;
  logic         i_inst_ready;
  logic [31:0]  o_inst;
  logic [31:0]  o_inst_pc;
  logic [2:0]   o_level;

  seq_fetch_unit dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_purge      (i_purge),
    .i_purge_pc   (i_purge_pc),
    .i_halt       (i_halt),
    .o_raddri     (o_raddri),
    .o_rcebi      (o_rcebi),
    .i_qi         (i_qi),
    .o_inst_valid (o_inst_valid),
    .i_inst_ready (i_inst_ready),
    .o_inst       (o_inst),
    .o_inst_pc    (o_inst_pc),
    .o_level      (o_level)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Word k holds instruction k*8+i in slot i.
  function automatic logic [255:0] mem_word(input logic [13:0] a);
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = 32'(a) * 32'd8 + 32'(i);
    return w;
  endfunction

  always @(posedge i_clk) begin
    if (!o_rcebi) i_qi <= mem_word(o_raddri);
    else          i_qi <= {8{32'hDEAD_BEEF}};
  end

  int n_vec = 0;
  int n_bad = 0;
  int n_xfer = 0;
  int n_reads = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: word addresses held in the buffer, one pending read.
  int unsigned q[$];
  bit          m_infl;
  logic [13:0] m_infl_addr;
  logic [13:0] m_faddr;
  logic [31:0] m_pc;

  task automatic cycle(input bit rst, input bit purge, input bit halt,
                       input bit ready, input logic [31:0] ppc);
    bit          issue;
    bit          e_valid;
    logic [13:0] e_addr;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    int          e_level;
    i_rst = rst; i_purge = purge; i_halt = halt; i_inst_ready = ready; i_purge_pc = ppc;
    #1;
    issue   = !rst && !purge && !halt && (q.size() + int'(m_infl) < 4);
    e_valid = !rst && !purge && (q.size() != 0);
    e_addr  = rst ? 14'h0 : m_faddr;
    e_inst  = (rst || q.size() == 0) ? 32'h0 : q[0] * 8 + 32'(m_pc[2:0]);
    e_pc    = rst ? RESET_PC : m_pc;
    e_level = rst ? 0 : q.size();
    check("rcebi",   64'(o_rcebi),      64'(!issue));
    check("raddri",  64'(o_raddri),     64'(e_addr));
    check("valid",   64'(o_inst_valid), 64'(e_valid));
    check("inst",    64'(o_inst),       64'(e_inst));
    check("inst_pc", 64'(o_inst_pc),    64'(e_pc));
    check("level",   64'(o_level),      64'(e_level));
    if (o_inst_valid && ready) n_xfer++;
    if (!o_rcebi) n_reads++;
    @(posedge i_clk);
    if (rst) begin
      q.delete(); m_infl = 0; m_faddr = 14'h0; m_pc = RESET_PC;
    end else if (purge) begin
      q.delete(); m_infl = 0; m_faddr = 14'(ppc >> 3); m_pc = ppc;
    end else begin
      if (e_valid && ready) begin
        if (m_pc[2:0] == 3'd7) void'(q.pop_front());
        m_pc = m_pc + 32'd1;
      end
      if (m_infl) q.push_back(32'(m_infl_addr));
      m_infl      = issue;
      m_infl_addr = m_faddr;
      if (issue) m_faddr = m_faddr + 14'd1;
    end
    @(negedge i_clk);
  endtask

  task automatic run(input int n, input bit halt, input bit ready);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, halt, ready, 32'h0);
  endtask

  initial begin
    logic [31:0] ppc;
    i_rst = 1'b1; i_purge = 1'b0; i_halt = 1'b0; i_inst_ready = 1'b0; i_purge_pc = '0;
    m_infl = 0; m_faddr = '0; m_pc = RESET_PC; m_infl_addr = '0;
    @(negedge i_clk);

    // Streaming from reset with READY=1: 16 transfers in 18 cycles, no bubbles.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    n_xfer = 0;
    run(18, 1'b0, 1'b1);
    check("t1_transfers", 64'(n_xfer), 64'd16);

    // Stalled consumer: exactly four reads, buffer full.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    n_reads = 0;
    run(10, 1'b0, 1'b0);
    check("t2_reads", 64'(n_reads), 64'd4);
    check("t2_level", 64'(o_level), 64'd4);

    // Redirect to 0x13 while the read issued in the previous cycle is in flight.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    run(4, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h13);
    run(12, 1'b0, 1'b1);

    // Redirect across the word-address wrap.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h1FFFE);
    run(12, 1'b0, 1'b1);

    // Back-to-back redirects: the last one wins.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h40);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h85);
    run(10, 1'b0, 1'b1);

    // Halt mid-stream, drain, then resume.
    run(6, 1'b0, 1'b1);
    n_reads = 0;
    run(40, 1'b1, 1'b1);
    check("t5_halt_reads", 64'(n_reads), 64'd0);
    check("t5_drained", 64'(o_level), 64'd0);
    run(12, 1'b0, 1'b1);

    // One-cycle reset mid-stream with a read in flight.
    run(3, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    run(12, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 3))
        0:       ppc = $urandom;
        1:       ppc = 32'h1FFF8 + 32'($urandom_range(0, 15));
        2:       ppc = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        default: ppc = 32'($urandom_range(0, 255));
      endcase
      cycle(($urandom % 300) == 0, ($urandom % 40) == 0, ($urandom % 10) == 0,
            ($urandom % 4) != 0, ppc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
